// File: rtl/regfile_wr_demux16.sv
// regfile_wr_demux16
//   Write side of the 16-entry register file. Write-back requests (rd + data)
//   arrive over a valid/ready handshake and are queued in a small FIFO. Each
//   cycle the FIFO head, if any, is retired: rd is decoded 1-of-16 and the
//   selected register is updated. All registers are exposed flat for the
//   rs1/rs2 read muxes.
//
// Parameters
//   W      data width of each register
//   DEPTH  write-back FIFO depth (power of 2, >= 2)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous reset, active low
//   wb_valid   write request present
//   wb_ready   FIFO can accept a request (from registered level only)
//   wb_rd      destination register index
//   wb_data    data to write
//   wr_hold    1 = do not retire FIFO entries this cycle
//   regs_flat  register contents; x(i) = regs_flat[i*W +: W]
//   wr_strobe  registered one-hot of the register written at the last edge
//   wb_level   FIFO occupancy, 0..DEPTH
//
// Configuration
//   REGWR_X0_ZERO_EN  when defined, x0 is hardwired to zero: a retire with
//                     rd=0 pops the entry but writes nothing and raises no
//                     strobe. When undefined, x0 is an ordinary register.

module regfile_wr_demux16 #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [3:0]                 wb_rd,
    input  logic [W-1:0]               wb_data,
    input  logic                       wr_hold,
    output logic [16*W-1:0]            regs_flat,
    output logic [15:0]                wr_strobe,
    output logic [$clog2(DEPTH):0]     wb_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

`ifdef REGWR_X0_ZERO_EN
    localparam int FirstReg = 1;
`else
    localparam int FirstReg = 0;
`endif

    // Write-back FIFO storage and control
    logic [3:0]    fifo_rd_q   [DEPTH];
    logic [W-1:0]  fifo_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;

    // Register file; x0 has no storage when it is hardwired to zero
    logic [W-1:0]  regs_q [FirstReg:15];
    logic [15:0]   strobe_q;

    logic          push;
    logic          pop;
    logic [3:0]    head_rd;
    logic [W-1:0]  head_data;
    logic [15:0]   strobe_d;

    // Ready never looks at the retire of the current cycle: no push-through when full.
    assign wb_ready  = rst_n & (level_q != LevelFull);
    assign push      = wb_valid & wb_ready;
    assign pop       = (level_q != '0) & ~wr_hold;
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // 1-of-16 decode of the head destination, qualified by the retire
    always_comb begin
        strobe_d = '0;
        if (pop) begin
            for (int i = FirstReg; i < 16; i++) begin
                strobe_d[i] = (head_rd == 4'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            strobe_q <= '0;
            for (int i = FirstReg; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_rd_q[wr_ptr_q]   <= wb_rd;
                fifo_data_q[wr_ptr_q] <= wb_data;
                wr_ptr_q              <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            // Head is read before the push lands, so a retire never writes
            // the entry pushed at the same edge.
            for (int i = FirstReg; i < 16; i++) begin
                if (strobe_d[i]) begin
                    regs_q[i] <= head_data;
                end
            end
            strobe_q <= strobe_d;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_flat
        if (g < FirstReg) begin : g_zero
            assign regs_flat[g*W +: W] = '0;
        end else begin : g_reg
            assign regs_flat[g*W +: W] = regs_q[g];
        end
    end

    assign wr_strobe = strobe_q;
    assign wb_level  = level_q;

endmodule

// File: tb/tb_regfile_wr_demux16.sv
// tb_regfile_wr_demux16
//   Directed bench for regfile_wr_demux16 (W=16, DEPTH=2). Inputs change 1
//   time unit after each rising edge; outputs are sampled at the same point.

module tb_regfile_wr_demux16;

    logic           clk;
    logic           rst_n;
    logic           wb_valid;
    logic           wb_ready;
    logic [3:0]     wb_rd;
    logic [15:0]    wb_data;
    logic           wr_hold;
    logic [255:0]   regs_flat;
    logic [15:0]    wr_strobe;
    logic [1:0]     wb_level;

    int checks = 0;
    int errors = 0;

    regfile_wr_demux16 #(
        .W     (16),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wr_hold   (wr_hold),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wb_level  (wb_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] xr(input int i);
        return regs_flat[i*16 +: 16];
    endfunction

    initial begin
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = 4'd0;
        wb_data  = 16'h0;
        wr_hold  = 1'b0;
        tick();
        tick();
        chk("rst_ready", 256'(wb_ready), 256'(0));
        chk("rst_level", 256'(wb_level), 256'(0));
        chk("rst_strobe", 256'(wr_strobe), 256'(0));
        chk("rst_regs", regs_flat, 256'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 256'(wb_ready), 256'(1));

        // 1: single write, one-edge latency
        wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 16'hA5A5;
        tick();
        wb_valid = 1'b0;
        chk("t1_level_acc", 256'(wb_level), 256'(1));
        chk("t1_x5_pre", 256'(xr(5)), 256'(0));
        chk("t1_strobe_pre", 256'(wr_strobe), 256'(0));
        tick();
        chk("t1_x5", 256'(xr(5)), 256'(16'hA5A5));
        chk("t1_strobe", 256'(wr_strobe), 256'(16'h0020));
        chk("t1_level", 256'(wb_level), 256'(0));
        tick();
        chk("t1_strobe_off", 256'(wr_strobe), 256'(0));

        // 2/3: hold fills the FIFO; release with a concurrent push attempt
        wr_hold = 1'b1;
        wb_valid = 1'b1; wb_rd = 4'd1; wb_data = 16'h1001;
        tick();
        chk("t2_level1", 256'(wb_level), 256'(1));
        wb_rd = 4'd2; wb_data = 16'h2002;
        tick();
        chk("t2_level2", 256'(wb_level), 256'(2));
        chk("t2_ready_full", 256'(wb_ready), 256'(0));
        wb_rd = 4'd3; wb_data = 16'h3003;
        tick();
        chk("t2_level_hold", 256'(wb_level), 256'(2));
        chk("t2_x1_hold", 256'(xr(1)), 256'(0));
        chk("t2_x2_hold", 256'(xr(2)), 256'(0));
        chk("t2_strobe_hold", 256'(wr_strobe), 256'(0));
        wr_hold = 1'b0;
        chk("t3_ready_full_retire", 256'(wb_ready), 256'(0));
        tick();
        chk("t3_x1", 256'(xr(1)), 256'(16'h1001));
        chk("t3_strobe1", 256'(wr_strobe), 256'(16'h0002));
        chk("t3_level1", 256'(wb_level), 256'(1));
        chk("t3_ready", 256'(wb_ready), 256'(1));
        tick();
        wb_valid = 1'b0;
        chk("t3_x2", 256'(xr(2)), 256'(16'h2002));
        chk("t3_strobe2", 256'(wr_strobe), 256'(16'h0004));
        chk("t3_level_pp", 256'(wb_level), 256'(1));
        chk("t3_x3_pre", 256'(xr(3)), 256'(0));
        tick();
        chk("t3_x3", 256'(xr(3)), 256'(16'h3003));
        chk("t3_strobe3", 256'(wr_strobe), 256'(16'h0008));
        chk("t3_level0", 256'(wb_level), 256'(0));
        chk("t3_x1_keep", 256'(xr(1)), 256'(16'h1001));

        // 4: same rd twice, last value wins
        wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 16'h1111;
        tick();
        wb_data = 16'h2222;
        tick();
        wb_valid = 1'b0;
        chk("t4_x7_first", 256'(xr(7)), 256'(16'h1111));
        chk("t4_strobe_a", 256'(wr_strobe), 256'(16'h0080));
        chk("t4_level", 256'(wb_level), 256'(1));
        tick();
        chk("t4_x7_last", 256'(xr(7)), 256'(16'h2222));
        chk("t4_strobe_b", 256'(wr_strobe), 256'(16'h0080));
        tick();
        chk("t4_strobe_off", 256'(wr_strobe), 256'(0));

        // 5: write to x0
        wb_valid = 1'b1; wb_rd = 4'd0; wb_data = 16'hFFFF;
        tick();
        wb_valid = 1'b0;
        tick();
`ifdef REGWR_X0_ZERO_EN
        chk("t5_x0", 256'(xr(0)), 256'(0));
        chk("t5_strobe", 256'(wr_strobe), 256'(0));
`else
        chk("t5_x0", 256'(xr(0)), 256'(16'hFFFF));
        chk("t5_strobe", 256'(wr_strobe), 256'(16'h0001));
`endif
        chk("t5_level", 256'(wb_level), 256'(0));

        // 6: reset with two pending entries
        wr_hold = 1'b1;
        wb_valid = 1'b1; wb_rd = 4'd9; wb_data = 16'h9999;
        tick();
        wb_rd = 4'd10; wb_data = 16'hAAAA;
        tick();
        chk("t6_level_pend", 256'(wb_level), 256'(2));
        wb_valid = 1'b0;
        wr_hold = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_ready_in_rst", 256'(wb_ready), 256'(0));
        tick();
        chk("t6_regs", regs_flat, 256'(0));
        chk("t6_level", 256'(wb_level), 256'(0));
        chk("t6_strobe", 256'(wr_strobe), 256'(0));
        chk("t6_ready_rst", 256'(wb_ready), 256'(0));
        rst_n = 1'b1;
        #1;
        chk("t6_ready_rel", 256'(wb_ready), 256'(1));
        tick();
        chk("t6_x9_discarded", 256'(xr(9)), 256'(0));
        chk("t6_strobe_after", 256'(wr_strobe), 256'(0));
        chk("t6_level_after", 256'(wb_level), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
